// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// Decode -> execute pipeline register.
//   * Captures the decoded control bundle, register ids, the immediate and
//     the two register-file operands on every rising clock edge.
//   * Detects a load-use hazard against the instruction currently in EX.
//     On a hazard it loads a one-cycle bubble and asserts stall_out so the
//     PC and IF/ID register hold the dependent instruction.
//   * A taken-branch flush from execute squashes the decode instruction.
//     The flush has priority over the hazard.
//   * Keeps a saturating count of load-use stall cycles.
//
// Optional feature (compile-time macro ID_EX_WB_BYPASS_EN):
//   When defined, a writeback to the same register that decode is reading
//   in the same cycle is forwarded into ex_data_1 / ex_data_2. This covers
//   the window where the register file still shows the old value. When the
//   macro is not defined, the operands are captured exactly as read.
//
// Parameters:
//   CTRL_W  width of the opaque decoded control bundle
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports:
//   clock, reset_n           clock; synchronous active-low reset
//   id_*                     decode-stage instruction fields and operands
//   ex_flush                 taken branch in execute: squash decode slot
//   wb_reg_write/id/value    writeback port (used only by the bypass)
//   stall_out                combinational: hold PC and IF/ID this cycle
//   ex_*                     registered execute-stage fields
//   stall_count              saturating count of load-use stall cycles
//
// Stall semantics: when stall_out is high, upstream must hold id_* stable
// for the next cycle. This register loads a bubble on that edge and then
// captures the held instruction on the following edge. A stall therefore
// always lasts exactly one cycle.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [31:0]       id_read_data_1,
  input  logic [31:0]       id_read_data_2,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_reg_id,
  input  logic [31:0]       wb_value,
  output logic              stall_out,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_data_1,
  output logic [31:0]       ex_data_2,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        hazard;
  logic [31:0] data_1_next;
  logic [31:0] data_2_next;

  // Load in EX whose destination is a source of the decode instruction.
  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
             ((ex_rd == id_rs) | (ex_rd == id_rt));
  end

  // reset_n is folded in so stall_out is 0 throughout reset, even before
  // the registers have been initialised.
  assign stall_out = hazard & ~ex_flush & reset_n;

`ifdef ID_EX_WB_BYPASS_EN
  logic bypass_1;
  logic bypass_2;

  always_comb begin
    bypass_1    = wb_reg_write & (wb_reg_id != 5'd0) & (wb_reg_id == id_rs);
    bypass_2    = wb_reg_write & (wb_reg_id != 5'd0) & (wb_reg_id == id_rt);
    data_1_next = bypass_1 ? wb_value : id_read_data_1;
    data_2_next = bypass_2 ? wb_value : id_read_data_2;
  end
`else
  // Without the bypass the writeback port is ignored.
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_reg_id, wb_value};

  always_comb begin
    data_1_next = id_read_data_1;
    data_2_next = id_read_data_2;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_data_1    <= 32'd0;
      ex_data_2    <= 32'd0;
      ex_imm       <= 32'd0;
      ex_ctrl      <= '0;
      stall_count  <= '0;
    end else if (ex_flush || hazard) begin
      // Bubble: only the control side is cleared. Ids and data hold, which
      // is harmless because ex_valid = 0 qualifies them downstream.
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      // A flush discards the stall, so only a pure hazard is counted.
      if (!ex_flush && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write & id_valid;
      ex_mem_read  <= id_mem_read & id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_data_1    <= data_1_next;
      ex_data_2    <= data_2_next;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Self-checking bench for id_ex_pipe_reg. A behavioural model of the EX
// stage contents is advanced once per clock edge from the hazard / flush /
// reset rules and compared against the DUT. The stall counter is built
// narrow so saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VEC_W  = 3 + 15 + 96 + CTRL_W + CNT_W;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic              id_valid;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic              id_reg_write, id_mem_read;
  logic [31:0]       id_read_data_1, id_read_data_2, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_flush;
  logic              wb_reg_write;
  logic [4:0]        wb_reg_id;
  logic [31:0]       wb_value;
  logic              stall_out;
  logic              ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [31:0]       ex_data_1, ex_data_2, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_count;

  id_ex_pipe_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .ex_flush(ex_flush),
    .wb_reg_write(wb_reg_write), .wb_reg_id(wb_reg_id), .wb_value(wb_value),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_data_1(ex_data_1), .ex_data_2(ex_data_2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the EX stage
  bit              m_valid, m_rw, m_mr;
  int              m_rs, m_rt, m_rd;
  logic [31:0]     m_d1, m_d2, m_imm;
  logic [CTRL_W-1:0] m_ctrl;
  int              m_cnt;

  logic [VEC_W-1:0] dut_vec;
  assign dut_vec = {ex_valid, ex_reg_write, ex_mem_read, ex_rs, ex_rt, ex_rd,
                    ex_data_1, ex_data_2, ex_imm, ex_ctrl, stall_count};

  function automatic logic [VEC_W-1:0] model_vec();
    logic [4:0] rs, rt, rd;
    logic [CNT_W-1:0] c;
    rs = 5'(m_rs); rt = 5'(m_rt); rd = 5'(m_rd); c = CNT_W'(m_cnt);
    return {m_valid, m_rw, m_mr, rs, rt, rd, m_d1, m_d2, m_imm, m_ctrl, c};
  endfunction

  // The instruction in EX is a load writing a register that decode reads.
  function automatic bit model_hazard();
    return id_valid && m_valid && m_mr && m_rd != 0 &&
           (m_rd == int'(id_rs) || m_rd == int'(id_rt));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && wb_reg_id != 0 && wb_reg_id == src) return wb_value;
`endif
    return rf;
  endfunction

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (!reset_n) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
    end else if (ex_flush || hz) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_ctrl = 0;
      if (!ex_flush) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      m_valid = id_valid;
      m_rw    = id_reg_write && id_valid;
      m_mr    = id_mem_read && id_valid;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_d1 = operand(id_rs, id_read_data_1);
      m_d2 = operand(id_rt, id_read_data_2);
      m_imm = id_imm; m_ctrl = id_ctrl;
    end
  endtask

  // One clock cycle: samples stall_out mid-cycle, advances the model on the
  // edge and returns 1 ns after it.
  task automatic cycle(output logic act_stall, output logic exp_stall);
    #3;
    act_stall = stall_out;
    exp_stall = reset_n && !ex_flush && model_hazard();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    reset_n = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_read_data_1 = 0; id_read_data_2 = 0;
    id_imm = 0; id_ctrl = 0; ex_flush = 0; wb_reg_write = 0; wb_reg_id = 0;
    wb_value = 0;
  endtask

  task automatic drive_instr(input int rs, input int rt, input int rd, input bit load);
    id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_reg_write = 1; id_mem_read = load;
    id_read_data_1 = $urandom; id_read_data_2 = $urandom;
    id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
  endtask

  task automatic test_reset();
    logic a, e;
    reset_n = 0; id_valid = 1; id_rs = 5'd7; id_rt = 5'd9; id_rd = 5'd11;
    id_reg_write = 1; id_mem_read = 1; id_read_data_1 = 32'h1111_1111;
    id_read_data_2 = 32'h2222_2222; id_imm = 32'h3333_3333; id_ctrl = '1;
    ex_flush = 1; wb_reg_write = 1; wb_reg_id = 5'd7; wb_value = 32'h4444_4444;
    for (int i = 0; i < 2; i++) begin
      cycle(a, e);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL reset_stall act=%b exp=0", a); end
    end
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", dut_vec); end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_model act=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_pass_through();
    logic a, e;
    drive_idle();
    id_valid = 1; id_rd = 5'd3; id_rs = 5'd1; id_rt = 5'd4;
    id_read_data_1 = 32'd5; id_imm = 32'hFFFF_FFFC; id_reg_write = 1;
    cycle(a, e);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL pass_stall act=%b exp=0", a); end
    checks++;
    if ({ex_valid, ex_rd, ex_data_1, ex_imm} !== {1'b1, 5'd3, 32'd5, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL pass_fields act=%b/%0d/%0d/%h exp=1/3/5/fffffffc", ex_valid, ex_rd, ex_data_1, ex_imm);
    end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL pass_model act=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_load_use();
    logic a, e;
    int cnt0;
    drive_idle();
    drive_instr(5, 6, 2, 1);
    cycle(a, e);
    cnt0 = m_cnt;
    drive_instr(2, 7, 8, 0);
    cycle(a, e);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL loaduse_stall act=%b exp=1", a); end
    checks++;
    if (ex_valid !== 1'b0 || int'(stall_count) != cnt0 + 1) begin
      errors++; $display("FAIL loaduse_bubble valid=%b cnt=%0d exp=0/%0d", ex_valid, stall_count, cnt0 + 1);
    end
    cycle(a, e);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL loaduse_release act=%b exp=0", a); end
    checks++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd2 || ex_rd !== 5'd8) begin
      errors++; $display("FAIL loaduse_capture valid=%b rs=%0d rd=%0d exp=1/2/8", ex_valid, ex_rs, ex_rd);
    end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL loaduse_model act=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_reg_zero();
    logic a, e;
    drive_idle();
    drive_instr(3, 4, 0, 1);
    cycle(a, e);
    drive_instr(0, 0, 5, 0);
    cycle(a, e);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL reg0_stall act=%b exp=0", a); end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL reg0_model act=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_flush_priority();
    logic a, e;
    int cnt0;
    drive_idle();
    drive_instr(1, 1, 2, 1);
    cycle(a, e);
    cnt0 = m_cnt;
    drive_instr(2, 3, 4, 0);
    ex_flush = 1;
    cycle(a, e);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL flush_stall act=%b exp=0", a); end
    checks++;
    if (ex_valid !== 1'b0 || int'(stall_count) != cnt0) begin
      errors++; $display("FAIL flush_bubble valid=%b cnt=%0d exp=0/%0d", ex_valid, stall_count, cnt0);
    end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL flush_model act=%h exp=%h", dut_vec, model_vec()); end
    ex_flush = 0;
  endtask

  task automatic test_bypass();
    logic a, e;
    logic [31:0] exp_d1;
    drive_idle();
    cycle(a, e);
    wb_reg_write = 1; wb_reg_id = 5'd1; wb_value = 32'd29;
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd6; id_read_data_1 = 32'd10;
    id_read_data_2 = 32'd77;
`ifdef ID_EX_WB_BYPASS_EN
    exp_d1 = 32'd29;
`else
    exp_d1 = 32'd10;
`endif
    cycle(a, e);
    checks++;
    if (ex_data_1 !== exp_d1 || ex_data_2 !== 32'd77) begin
      errors++; $display("FAIL bypass_data d1=%0d d2=%0d exp=%0d/77", ex_data_1, ex_data_2, exp_d1);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic a, e;
    drive_idle();
    drive_instr(1, 1, 3, 1);
    cycle(a, e);
    drive_instr(3, 1, 4, 0);
    reset_n = 0;
    cycle(a, e);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rstmid_stall act=%b exp=0", a); end
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL rstmid_outputs act=%h exp=0", dut_vec); end
    reset_n = 1;
  endtask

  task automatic test_back_to_back();
    logic a, e;
    int stalls;
    drive_idle();
    stalls = 0;
    drive_instr(1, 2, 4, 1);
    cycle(a, e);
    // Three dependent loads to the same rd, each held through its stall.
    for (int k = 0; k < 3; k++) begin
      drive_instr(4, 0, 4, 1);
      for (int j = 0; j < 2; j++) begin
        cycle(a, e);
        if (a === 1'b1) stalls++;
        checks++;
        if (a !== e) begin errors++; $display("FAIL b2b_stall k=%0d j=%0d act=%b exp=%b", k, j, a, e); end
      end
    end
    checks++;
    if (stalls != 3) begin errors++; $display("FAIL b2b_count act=%0d exp=3", stalls); end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL b2b_model act=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_saturation();
    logic a, e;
    drive_idle();
    for (int k = 0; k < CNT_MAX + 4; k++) begin
      drive_instr(1, 1, 6, 1);
      cycle(a, e);
      drive_instr(6, 2, 7, 0);
      cycle(a, e);
      cycle(a, e);
    end
    checks++;
    if (int'(stall_count) != CNT_MAX) begin errors++; $display("FAIL sat_count act=%0d exp=%0d", stall_count, CNT_MAX); end
  endtask

  task automatic test_random();
    logic a, e;
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
      id_read_data_1 = $urandom; id_read_data_2 = $urandom; id_imm = $urandom;
      id_ctrl = CTRL_W'($urandom);
      ex_flush = ($urandom_range(0, 9) == 0);
      wb_reg_write = 1'($urandom); wb_reg_id = 5'($urandom_range(0, 3));
      wb_value = $urandom;
      cycle(a, e);
      checks++;
      if (a !== e) begin errors++; $display("FAIL rand_stall i=%0d act=%b exp=%b", i, a, e); end
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL rand_state i=%0d act=%h exp=%h", i, dut_vec, model_vec()); end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_pass_through();
    test_load_use();
    test_reg_zero();
    test_flush_priority();
    test_bypass();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Pipeline register between the decode stage and the execute stage. It captures decoded control fields, the immediate, and the two operands from the register file. It detects load-use hazards and inserts a one-cycle bubble while stalling upstream. It also squashes its contents on a taken-branch flush from execute.

## Interface
Parameters:
- CTRL_W, 8, width of the opaque decoded control bundle (ALU op, branch, mem_write, ...)
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  5  source register ids (also drive reg_file read ports)
- id_rd  in  5  destination register id
- id_reg_write  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- id_read_data_1, id_read_data_2  in  32  reg_file outputs for id_rs / id_rt
- id_imm  in  32  sign-extended immediate
- id_ctrl  in  CTRL_W  remaining decoded control
- ex_flush  in  1  taken branch resolved in execute; squash decode instruction
- wb_reg_write  in  1  writeback is writing reg_file this cycle
- wb_reg_id  in  5  writeback destination
- wb_value  in  32  writeback data
- stall_out  out  1  hold PC and IF/ID register this cycle (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered
- ex_rs, ex_rt, ex_rd  out  5  registered
- ex_data_1, ex_data_2, ex_imm  out  32  registered
- ex_ctrl  out  CTRL_W  registered
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt)).
- stall_out = hazard & ~ex_flush & reset_n.
- Each rising edge, in priority order:
  - !reset_n: all ex_* outputs are 0 and stall_count is 0.
  - ex_flush: load a bubble.
  - hazard: load a bubble and increment stall_count (saturates at all-ones, no wrap).
  - Otherwise: load the id_* fields. ex_valid = id_valid. ex_reg_write = id_reg_write & id_valid. ex_mem_read = id_mem_read & id_valid.
- Bubble: ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0, ex_ctrl = 0. Data and id fields (ex_rs/rt/rd/data/imm) hold their previous value.
- A stall lasts exactly one cycle. The bubble clears ex_valid, so hazard deasserts on the next cycle and the held decode instruction is then captured.
- Register 0 never produces a hazard.
- Flush during a hazard: flush wins, stall_out = 0, and stall_count does not increment.

## Timing
- Latency: one cycle from id_* to ex_*.
- stall_out is combinational in the same cycle from the ex_* registers and the id_* inputs. It is 0 throughout reset.
- Reset value: every registered output is 0, and stall_count is 0.
- Reset mid-stall: the bubble is discarded and stall_out = 0 on the cycle reset is sampled low.
- Back-to-back loads to the same rd: each load-use pair costs exactly one bubble.

## Configuration
- ID_EX_WB_BYPASS_EN defined:
  - When wb_reg_write, wb_reg_id != 0 and wb_reg_id == id_rs, ex_data_1 captures wb_value instead of id_read_data_1.
  - The same rule applies to id_rt and ex_data_2.
  - Covers the reg_file write-on-edge read-old-value window.
- Not defined:
  - Operands are captured exactly as read.
  - Software must separate a writeback and a dependent decode by one instruction.

## Test plan
- Reset:
  - Stimulus: reset_n = 0 for 2 cycles with all inputs nonzero.
  - Response: every ex_* output = 0, stall_count = 0, stall_out = 0.
- Pass-through:
  - Stimulus: id_valid = 1, id_rd = 3, id_read_data_1 = 5, id_imm = 0xFFFFFFFC, id_reg_write = 1.
  - Response: next edge ex_valid = 1, ex_rd = 3, ex_data_1 = 5, ex_imm = 0xFFFFFFFC, stall_out = 0.
- Load-use:
  - Stimulus: load with rd = 2 into EX, then decode an instruction with rs = 2.
  - Response: stall_out = 1 for exactly one cycle; ex_valid = 0 the next cycle; the dependent instruction enters EX one cycle later; stall_count = 1.
- Register 0:
  - Stimulus: load with rd = 0 followed by decode with rs = 0.
  - Response: stall_out stays 0.
- Flush priority:
  - Stimulus: hazard present and ex_flush = 1 in the same cycle.
  - Response: stall_out = 0, ex_valid = 0 next edge, stall_count unchanged.
- Bypass (macro defined):
  - Stimulus: wb_reg_write = 1, wb_reg_id = 1, wb_value = 29, id_rs = 1, id_read_data_1 = 10.
  - Response: ex_data_1 = 29.
  - Without the macro: ex_data_1 = 10.
